// File: rtl/floppy_sdram_pkg.sv
// Shared types and constants for the floppy-to-SDRAM request adapter.
package floppy_sdram_pkg;

  localparam int          TIMEOUT_DEFAULT = 1023;
  localparam int          CNT_W           = 10;
  localparam logic [7:0]  RD_FAIL_BYTE    = 8'hFF;
  localparam int          STATUS_OVERRUN  = 0;
  localparam int          STATUS_TIMEOUT  = 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  // Every registered value of the adapter, so next-state logic can work on one bundle.
  typedef struct packed {
    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               wr;
    logic               lane;
    logic [22:0]        adrs;
    logic [7:0]         data_w;
    logic [7:0]         data_o;
    logic               busy;
    logic               rd_req;
    logic               wr_req;
    logic               byte_en;
    logic               halfword;
    logic [1:0]         status;
  } regs_t;

  localparam regs_t REGS_RESET = '{
    state:    IDLE,
    cnt:      '0,
    wr:       1'b0,
    lane:     1'b0,
    adrs:     '0,
    data_w:   '0,
    data_o:   '0,
    busy:     1'b0,
    rd_req:   1'b0,
    wr_req:   1'b0,
    byte_en:  1'b1,
    halfword: 1'b0,
    status:   '0
  };

endpackage

// File: rtl/floppy_sdram_port_if.sv
// Floppy-side and arbiter-side signals of the adapter; slave is the adapter's view.
interface floppy_sdram_port_if;
  logic [22:0] f_addr;
  logic [7:0]  f_data_i;
  logic [7:0]  f_data_o;
  logic        f_read;
  logic        f_write;
  logic        f_busy;
  logic [22:0] arb_adrs;
  logic [7:0]  arb_data_w;
  logic [15:0] arb_data_r;
  logic        arb_read;
  logic        arb_write;
  logic        arb_byte;
  logic        arb_halfword;
  logic        arb_busy;
  logic [1:0]  status;

  modport master (
    output f_addr, f_data_i, f_read, f_write, arb_data_r, arb_busy,
    input  f_data_o, f_busy, arb_adrs, arb_data_w, arb_read, arb_write,
           arb_byte, arb_halfword, status
  );

  modport slave (
    input  f_addr, f_data_i, f_read, f_write, arb_data_r, arb_busy,
    output f_data_o, f_busy, arb_adrs, arb_data_w, arb_read, arb_write,
           arb_byte, arb_halfword, status
  );
endinterface

// File: rtl/floppy_rdcache.sv
// One-halfword read cache: a tag, a 16-bit word and a valid bit.
module floppy_rdcache (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] lookup_tag,
  output logic        hit,
  output logic [15:0] word,
  input  logic        fill,
  input  logic [21:0] fill_tag,
  input  logic [15:0] fill_word,
  input  logic        wr_en,
  input  logic [21:0] wr_tag,
  input  logic        wr_lane,
  input  logic [7:0]  wr_data,
  input  logic        invalidate
);
  logic        valid;
  logic [21:0] tag;
  logic [15:0] data;

  assign hit  = valid && (tag == lookup_tag);
  assign word = data;

  always_ff @(posedge clk) begin
    if (reset)           valid <= 1'b0;
    else if (invalidate) valid <= 1'b0;
    else if (fill)       valid <= 1'b1;
  end

  // NOTE: tag and word carry no reset; nothing reads them until valid is set by a fill.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag  <= fill_tag;
      data <= fill_word;
    end else if (wr_en && valid && (wr_tag == tag)) begin
      if (wr_lane) data[15:8] <= wr_data;
      else         data[7:0]  <= wr_data;
    end
  end
endmodule

// File: rtl/floppy_sdram_port.sv
// Turns floppy one-cycle strobes into held sdram_arbitre disk_* requests.
// Define FLOPPY_SDRAM_RDCACHE_EN to add the one-halfword read cache.
module floppy_sdram_port
  import floppy_sdram_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  floppy_sdram_port_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
`ifdef FLOPPY_SDRAM_RDCACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  regs_t            q, d;
  logic             strobe;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       hit_byte, rd_byte;
  logic             cache_hit, cache_fill, cache_wr, cache_inval;
  logic [15:0]      cache_word;

  always_comb begin
    d           = q;
    cache_fill  = 1'b0;
    cache_wr    = 1'b0;
    cache_inval = 1'b0;
    strobe      = bus.f_read | bus.f_write;
    cnt_inc     = q.cnt + CNT_W'(1);
    hit_byte    = bus.f_addr[0] ? cache_word[15:8] : cache_word[7:0];
    rd_byte     = (CACHE_EN && q.lane) ? bus.arb_data_r[15:8] : bus.arb_data_r[7:0];

    case (q.state)
      IDLE, DONE: begin
        d.state = IDLE;
        if (bus.f_read && !bus.f_write && cache_hit) begin
          d.data_o = hit_byte;
        end else if (strobe) begin
          d.state    = REQ;
          d.cnt      = '0;
          d.wr       = bus.f_write;
          d.lane     = bus.f_addr[0];
          d.busy     = 1'b1;
          d.data_w   = bus.f_data_i;
          d.rd_req   = !bus.f_write;
          d.wr_req   = bus.f_write;
          cache_wr   = bus.f_write;
          if (bus.f_write || !CACHE_EN) begin
            d.adrs     = bus.f_addr;
            d.byte_en  = 1'b1;
            d.halfword = 1'b0;
          end else begin
            d.adrs     = {bus.f_addr[22:1], 1'b0};
            d.byte_en  = 1'b0;
            d.halfword = 1'b1;
          end
        end
      end
      REQ, WAIT: begin
        d.cnt = cnt_inc;
        // A completion in WAIT beats a timeout landing on the same cycle.
        if (q.state == WAIT && !bus.arb_busy) begin
          d.state = DONE;
          d.busy  = 1'b0;
          if (!q.wr) begin
            d.data_o   = rd_byte;
            cache_fill = 1'b1;
          end
        end else if (cnt_inc == CNT_LIMIT) begin
          d.state                 = DONE;
          d.busy                  = 1'b0;
          d.rd_req                = 1'b0;
          d.wr_req                = 1'b0;
          d.data_o                = RD_FAIL_BYTE;
          d.status[STATUS_TIMEOUT] = 1'b1;
          cache_inval             = 1'b1;
        end else if (q.state == REQ && bus.arb_busy) begin
          d.state  = WAIT;
          d.rd_req = 1'b0;
          d.wr_req = 1'b0;
        end
      end
      default: d.state = IDLE;
    endcase

    if (strobe && q.busy) d.status[STATUS_OVERRUN] = 1'b1;
  end

  // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) q <= REGS_RESET;
    else       q <= d;
  end

`ifdef FLOPPY_SDRAM_RDCACHE_EN
  floppy_rdcache u_rdcache (
    .clk        (clk),
    .reset      (reset),
    .lookup_tag (bus.f_addr[22:1]),
    .hit        (cache_hit),
    .word       (cache_word),
    .fill       (cache_fill),
    .fill_tag   (q.adrs[22:1]),
    .fill_word  (bus.arb_data_r),
    .wr_en      (cache_wr),
    .wr_tag     (bus.f_addr[22:1]),
    .wr_lane    (bus.f_addr[0]),
    .wr_data    (bus.f_data_i),
    .invalidate (cache_inval)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_word = '0;
  logic unused_cache;
  assign unused_cache = &{1'b0, cache_fill, cache_wr, cache_inval};
`endif

  assign bus.f_data_o     = q.data_o;
  assign bus.f_busy       = q.busy;
  assign bus.arb_adrs     = q.adrs;
  assign bus.arb_data_w   = q.data_w;
  assign bus.arb_read     = q.rd_req;
  assign bus.arb_write    = q.wr_req;
  assign bus.arb_byte     = q.byte_en;
  assign bus.arb_halfword = q.halfword;
  assign bus.status       = q.status;
endmodule
